// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO geometry and the occupancy-counter width helper shared by fifo_buf and fifo_ram
package fifo_pkg;
  localparam int WIDTH_D = 32;
  localparam int DEPTH_D = 15;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x WIDTH register array; ports clk, we/waddr/wdata (sync write), raddr/rdata (async read)
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_buf.sv
// fifo_buf: single-clock FWFT FIFO; ports clk, rst (async active-low), push/datain, pull/dataout, full, empty, count
module fifo_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         datain,
  input  logic                     pull,
  output logic [WIDTH-1:0]         dataout,
  output logic                     full,
  output logic                     empty,
  output logic [cnt_w(DEPTH)-1:0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [AW-1:0] wp, rp;
  logic [WIDTH-1:0] rd;
  logic do_push, do_pull;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_pull = pull && !empty;
  assign do_push = push && (!full || pull);
  assign dataout = empty ? '0 : rd;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp == AW'(DEPTH - 1) ? '0 : AW'(wp + 1);
      if (do_pull) rp <= rp == AW'(DEPTH - 1) ? '0 : AW'(rp + 1);
      count <= count + CW'(do_push) - CW'(do_pull);
    end
  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(do_push),
    .waddr(wp),
    .wdata(datain),
    .raddr(rp),
    .rdata(rd)
  );
endmodule

// File: tb/tb_fifo_buf.sv
// tb_fifo_buf: table vectors, directed corner sequences and random traffic checked against a queue model
module tb_fifo_buf;
  localparam int DEPTH = 15;
  logic clk = 0, rst = 0, push = 0, pull = 0;
  logic [31:0] datain = '0, dataout;
  logic full, empty;
  logic [3:0] count;
  int checks = 0, errors = 0;
  logic [31:0] q[$];

  fifo_buf #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .datain(datain), .pull(pull),
    .dataout(dataout), .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit p; bit l; logic [31:0] d;
    int ec; logic [31:0] eo; bit ee; bit ef;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic chk_reset(string n);
    chk({n, "_empty"}, 32'(empty), 1);
    chk({n, "_full"}, 32'(full), 0);
    chk({n, "_count"}, 32'(count), 0);
    chk({n, "_dataout"}, dataout, 0);
  endtask

  task automatic cyc(bit p, bit l, logic [31:0] d);
    bit ap, al;
    push = p; pull = l; datain = d;
    #1;
    chk("head_at_pull", dataout, q.size() != 0 ? q[0] : 32'h0);
    @(posedge clk);
    al = l && q.size() != 0;
    ap = p && (q.size() < DEPTH || l);
    if (al) void'(q.pop_front());
    if (ap) q.push_back(d);
    #1;
    chk("count", 32'(count), q.size());
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("dataout", dataout, q.size() != 0 ? q[0] : 32'h0);
    push = 0; pull = 0;
  endtask

  initial begin
    tbl[0] = '{1, 0, 32'h0000_00A1, 1, 32'h0000_00A1, 0, 0};
    tbl[1] = '{1, 0, 32'h0000_00B2, 2, 32'h0000_00A1, 0, 0};
    tbl[2] = '{1, 1, 32'h0000_00C3, 2, 32'h0000_00B2, 0, 0};
    tbl[3] = '{0, 1, 32'h0,         1, 32'h0000_00C3, 0, 0};
    tbl[4] = '{0, 1, 32'h0,         0, 32'h0,         1, 0};
    tbl[5] = '{0, 1, 32'h0,         0, 32'h0,         1, 0};
    tbl[6] = '{1, 1, 32'h0000_00D4, 1, 32'h0000_00D4, 0, 0};
    tbl[7] = '{0, 1, 32'h0,         0, 32'h0,         1, 0};

    #1;
    chk_reset("in_reset");
    #12 rst = 1;

    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h0);
    chk_reset("idle_pull");

    foreach (tbl[i]) begin
      cyc(tbl[i].p, tbl[i].l, tbl[i].d);
      chk("tbl_count", 32'(count), tbl[i].ec);
      chk("tbl_dataout", dataout, tbl[i].eo);
      chk("tbl_empty", 32'(empty), 32'(tbl[i].ee));
      chk("tbl_full", 32'(full), 32'(tbl[i].ef));
    end

    for (int i = 0; i < DEPTH; i++) cyc(1, 0, $urandom);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), DEPTH);
    cyc(1, 0, 32'hDEAD_BEEF);
    chk("ovf_count", 32'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("ovf_never_read", 32'(dataout == 32'hDEAD_BEEF), 0);
      cyc(0, 1, 32'h0);
    end
    chk("drain_empty", 32'(empty), 1);

    for (int i = 0; i < 10; i++) cyc(1, 0, $urandom);
    for (int i = 0; i < 10; i++) cyc(0, 1, 32'h0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, $urandom);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 32'h0);

    for (int i = 0; i < 5; i++) cyc(1, 0, $urandom);
    for (int i = 0; i < 4; i++) cyc(1, 1, $urandom);
    chk("both_at5_count", 32'(count), 5);
    for (int i = 0; i < 10; i++) cyc(1, 0, $urandom);
    cyc(1, 1, 32'h1234_5678);
    chk("both_at_full_count", 32'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 32'h0);
    cyc(1, 1, 32'hCAFE_0001);
    chk("both_at_empty_count", 32'(count), 1);
    chk("both_at_empty_out", dataout, 32'hCAFE_0001);
    cyc(0, 1, 32'h0);

    for (int i = 0; i < 1600; i++) begin
      int pb, lb;
      pb = (i / 200) % 2 ? 80 : 30;
      lb = (i / 200) % 2 ? 30 : 80;
      cyc($urandom_range(0, 99) < pb, $urandom_range(0, 99) < lb, $urandom);
    end

    while (q.size() != 0) cyc(0, 1, 32'h0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 32'h100 + i);
    #3 rst = 0;
    #1;
    chk_reset("async_reset");
    q.delete();
    #2 rst = 1;
    cyc(1, 0, 32'h5EED_0000);
    cyc(0, 1, 32'h0);
    chk_reset("post_reset_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
